// File: rtl/pmips_regfile.sv
// pmips_regfile: parametrised register file with one write port and two registered read ports.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a reader of the same register.
module pmips_regfile #(
    parameter int unsigned N        = 8,
    parameter int unsigned AW       = 3,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [N-1:0]  rdata1,
    output logic [N-1:0]  rdata2
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [N-1:0] regs [DEPTH];
    logic         wr_ok;
    logic [N-1:0] rd1_next;
    logic [N-1:0] rd2_next;

    always_comb begin
        wr_ok = we && !((ZERO_REG != 0) && (waddr == '0));
    end

    // Zero-register override is applied last so it also beats forwarding.
    always_comb begin
        rd1_next = regs[raddr1];
        rd2_next = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        if (we && (raddr1 == waddr)) rd1_next = wdata;
        if (we && (raddr2 == waddr)) rd2_next = wdata;
`endif
        if ((ZERO_REG != 0) && (raddr1 == '0)) rd1_next = '0;
        if ((ZERO_REG != 0) && (raddr2 == '0)) rd2_next = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i[AW-1:0]] <= '0;
            end
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (wr_ok) regs[waddr] <= wdata;
            if (re1) rdata1 <= rd1_next;
            if (re2) rdata2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_pmips_regfile.sv
// Scoreboard bench for pmips_regfile: three parameterisations driven in lockstep,
// expected read data queued by the driver and checked by an independent monitor.
module tb_pmips_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, re1, re2;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [15:0] wdata;

    logic [7:0]  r1a, r2a, r1c, r2c;
    logic [15:0] r1b, r2b;

    int unsigned total = 0;
    int unsigned bad   = 0;

    localparam int unsigned NI = 3;
    localparam int unsigned NK [NI]  = '{8, 16, 8};
    localparam int unsigned AK [NI]  = '{3, 5, 3};
    localparam int unsigned ZK [NI]  = '{1, 1, 0};
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [15:0] mem  [NI][32];
    logic [15:0] last [NI][2];
    logic [95:0] exp_q [$];

    always #5 clk = ~clk;

    pmips_regfile #(.N(8), .AW(3), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
        .re1(re1), .raddr1(raddr1[2:0]), .re2(re2), .raddr2(raddr2[2:0]),
        .rdata1(r1a), .rdata2(r2a)
    );

    pmips_regfile #(.N(16), .AW(5), .ZERO_REG(1)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
        .rdata1(r1b), .rdata2(r2b)
    );

    pmips_regfile #(.N(8), .AW(3), .ZERO_REG(0)) dut_c (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr[2:0]), .wdata(wdata[7:0]),
        .re1(re1), .raddr1(raddr1[2:0]), .re2(re2), .raddr2(raddr2[2:0]),
        .rdata1(r1c), .rdata2(r2c)
    );

    function automatic logic [15:0] act(input int unsigned idx);
        case (idx)
            0: act = {8'h00, r1a};
            1: act = {8'h00, r2a};
            2: act = r1b;
            3: act = r2b;
            4: act = {8'h00, r1c};
            default: act = {8'h00, r2c};
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 32; a++) mem[k][a] = '0;
            last[k][0] = '0;
            last[k][1] = '0;
        end
    endtask

    // Drive one edge's worth of inputs and queue what each register file must show after it.
    task automatic cycle(input bit w, input logic [4:0] wa, input logic [15:0] wd,
                         input bit e1, input logic [4:0] a1,
                         input bit e2, input logic [4:0] a2);
        logic [95:0] e;
        @(negedge clk);
        we = w; waddr = wa; wdata = wd;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            int unsigned am = (1 << AK[k]) - 1;
            int unsigned dm = (1 << NK[k]) - 1;
            int unsigned wak = wa & am;
            int unsigned wdk = wd & dm;
            for (int p = 0; p < 2; p++) begin
                bit          en  = (p == 0) ? e1 : e2;
                int unsigned ra  = ((p == 0) ? a1 : a2) & am;
                logic [15:0] v;
                if (!en)                           v = last[k][p];
                else if (ZK[k] != 0 && ra == 0)    v = '0;
                else if (BYP && w && ra == wak)    v = wdk[15:0];
                else                               v = mem[k][ra];
                last[k][p] = v;
                e[(k*2+p)*16 +: 16] = v;
            end
            if (w && !(ZK[k] != 0 && wak == 0)) mem[k][wak] = wdk[15:0];
        end
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string nm);
        for (int unsigned i = 0; i < 6; i++) begin
            total++;
            if (act(i) !== 16'h0000) begin
                bad++;
                $display("FAIL %s out%0d got=%h want=0000", nm, i, act(i));
            end
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1; we = 1'b0; re1 = 1'b0; re2 = 1'b0;
        #1;
        check_zero("async_reset");
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: one queued expectation per driven edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                logic [95:0] e;
                e = exp_q.pop_front();
                for (int unsigned i = 0; i < 6; i++) begin
                    total++;
                    if (act(i) !== e[i*16 +: 16]) begin
                        bad++;
                        $display("FAIL rdata inst%0d port%0d got=%h want=%h @%0t",
                                 i / 2, i % 2 + 1, act(i), e[i*16 +: 16], $time);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; we = 1'b0; re1 = 1'b0; re2 = 1'b0;
        waddr = '0; raddr1 = '0; raddr2 = '0; wdata = '0;
        model_clear();
        #2;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Writes with reads disabled, then stepped reads on both ports.
        for (int i = 1; i <= 4; i++) cycle(1, 5'(i), 16'(9 + i), 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 1, 5'(i), 1, 5'(i));

        // Reset mid-operation, then all written registers read back as zero.
        async_reset();
        for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 1, 5'(i), 1, 5'(5 - i));

        // Zero register with and without ZERO_REG.
        cycle(1, 0, 16'h00FF, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 1, 0);

        // Read-enable hold.
        cycle(1, 3, 16'd12, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 3, 0, 0);
        cycle(1, 3, 16'd99, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 3, 0, 0);
        cycle(0, 0, 0, 1, 3, 0, 0);

        // Same-edge read and write of one register.
        cycle(1, 5, 16'd7, 0, 0, 0, 0);
        cycle(1, 5, 16'd42, 1, 5, 1, 5);
        cycle(0, 0, 0, 1, 5, 1, 5);
        cycle(1, 0, 16'h5A5A, 1, 0, 1, 0);

        // Wide configuration: top register and discarded register-0 write.
        cycle(1, 31, 16'hBEEF, 0, 0, 0, 0);
        cycle(1, 0, 16'h1234, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 1, 31);

        // Random traffic, biased toward low addresses for frequent collisions.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] wa, a1, a2;
            wa = ($urandom % 2 != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a1 = ($urandom % 2 != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            a2 = ($urandom % 4 == 0) ? a1 : 5'($urandom);
            cycle($urandom % 2 != 0, wa, 16'($urandom),
                  $urandom % 4 != 0, a1, $urandom % 4 != 0, a2);
            if (i == 200) async_reset();
        end

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
